mmio_timer_array: RTL and testbench
===================================

Name: mmio_timer_array

Overview:
- Parametrised multi-channel countdown timer peripheral on the CPU's memory-mapped device bus, behind the system bridge next to the 32-bit input device.
- Raises per-channel interrupt requests that feed the CP0 interrupt-pending lines of the multicycle MIPS core.
- Generalises the single fixed timer: N channels, one-shot or auto-reload mode, per-channel mask, combined IRQ.

Parameters:
- NCH, 2, number of timer channels (1..8).
- AW, 8, byte-address width of the device window; NCH*16 must be <= 2**AW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  bus write strobe for this device, already address-decoded by the bridge.
- addr  in  AW  byte address within the window; addr[1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr, zero latency.
- irq  out  NCH  per-channel interrupt request.
- irq_any  out  1  OR of irq.

Behaviour:
- Channel c occupies byte offsets 16c..16c+15:
  - +0 CTRL (RW): bit0 EN; bits2:1 MODE, 00 one-shot, 01 auto-reload, 1x reserved and treated as 00; bit3 IM, interrupt mask where 1 means enabled; other bits read 0.
  - +4 PRESET (RW).
  - +8 COUNT (RO; writes ignored).
  - +12 reserved, reads 0.
- Unmapped offsets read 0; writes to them are ignored.
- Reset: all CTRL, PRESET and COUNT = 0; all states IDLE; irq = 0; irq_any = 0; rdata follows addr against the cleared registers.
- Per-channel FSM, one transition per clock edge:
  - IDLE: when EN = 1, go to LOAD; COUNT holds its value.
  - LOAD: COUNT <= PRESET. Go to CNT, or to INT directly if PRESET = 0.
  - CNT: if EN = 0, go to IDLE with COUNT frozen. If COUNT > 1, COUNT <= COUNT-1. If COUNT = 1, COUNT <= 0 and go to INT.
  - INT: set the channel flag. MODE 00: clear EN, go to IDLE. MODE 01: go to LOAD.
- IRQ:
  - irq[c] = flag[c] & IM[c].
  - MODE 00: flag is sticky until any write to that channel's CTRL; it clears on the same edge as the write.
  - MODE 01: flag is high for exactly the INT cycle, a one-cycle pulse.
- Timing:
  - irq rises PRESET+2 edges after the CTRL-write edge.
  - Auto-reload period is PRESET+2 cycles.
  - PRESET = 0 gives 2 cycles.
- Simultaneous events:
  - A PRESET write during CNT affects only the next LOAD.
  - A CTRL write that coincides with the INT edge takes priority: the written EN/MODE values win, and the flag is cleared.
  - Channels are fully independent, and a same-cycle interrupt on several channels sets all corresponding irq bits.
- Width: COUNT and PRESET are 32 bits unsigned. No wrap past 0, because the FSM never decrements from 0.
- rst asserted mid-count: every channel returns to the reset values on that edge, and irq drops the following cycle.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- When defined:
  - CTRL bits 15:8 become PS (RW, reset 0).
  - Each channel gets an 8-bit prescale counter that is cleared in LOAD.
  - CNT decrements only when the prescaler reaches PS, so PS = 0 means every cycle.
  - irq timing becomes (PRESET)*(PS+1)+2 edges.
- When undefined: bits 15:8 read 0, writes to them are ignored, and CNT decrements every cycle.

Decomposition:
- Package timer_pkg holds:
  - the FSM state encoding (IDLE, LOAD, CNT, INT);
  - register offsets OFF_CTRL = 0, OFF_PRESET = 4, OFF_COUNT = 8 and channel stride 16;
  - CTRL bit positions and the MODE encodings.
- Sub-module timer_channel contains one channel's registers, FSM and optional prescaler.
- The top level instantiates NCH copies via generate and adds:
  - address decode (channel index = addr[AW-1:4]);
  - the read mux;
  - the irq_any reduction.

Test Plan:
- Reset, then read all offsets -> 0. Write COUNT = 0xFFFF -> still reads 0.
- Ch0: PRESET = 5, CTRL = 0x9 (EN, one-shot, IM) -> irq[0] rises exactly 7 edges after the CTRL write; COUNT reads 0; CTRL reads 0x8. irq stays high until CTRL is written with 0x8, and drops on that edge.
- Ch1: PRESET = 3, CTRL = 0xB (auto-reload) -> irq[1] pulses one cycle wide every 5 cycles for 4 periods; irq_any mirrors it; ch0 stays unaffected.
- Ch0 counting with PRESET = 100: write CTRL = 0 when COUNT = 60 -> next cycle IDLE, COUNT frozen at 59, no irq. Rewrite EN -> reload from 100.
- PRESET = 0 with CTRL = 0x1 (IM = 0) -> reaches INT in 2 cycles, flag set, irq = 0. Then write CTRL = 0x8 -> flag cleared, irq stays 0.
- Assert rst during ch1 auto-reload -> next cycle all registers 0 and irq = 0. With TIMER_PRESCALE_EN, PS = 3 and PRESET = 2 -> irq after 10 edges.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_pkg
//  Purpose  : Shared definitions for the MMIO timer array: channel FSM
//             encoding, register offsets, CTRL bit positions, MODE codes.
//  Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Per-channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Register offsets inside one 16-byte channel slot
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam int         CH_STRIDE  = 16;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PS_LO   = 8;
    localparam int CTRL_PS_HI   = 15;

    // MODE encodings; 1x is reserved and behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
//  Module   : timer_channel
//  Purpose  : One countdown channel: CTRL/PRESET/COUNT registers, the
//             IDLE/LOAD/CNT/INT FSM, interrupt flag and optional prescaler
//             (enabled by macro TIMER_PRESCALE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_we_i,
    input  logic        preset_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] preset_o,
    output logic [31:0] count_o,
    output logic        irq_o
);

    timer_state_e state_q, state_d;
    logic         en_q, en_d;
    logic [1:0]   mode_q, mode_d;
    logic         im_q, im_d;
    logic         flag_q, flag_d;
    logic [31:0]  preset_q, preset_d;
    logic [31:0]  count_q, count_d;
    logic         w_tick;

`ifdef TIMER_PRESCALE_EN
    logic [7:0]   ps_q, ps_d;
    logic [7:0]   pscnt_q, pscnt_d;

    // ">=" keeps the prescaler sane if PS is lowered while counting
    assign w_tick = (pscnt_q >= ps_q);
    assign ctrl_o = {16'd0, ps_q, 4'd0, im_q, mode_q, en_q};
`else
    assign w_tick = 1'b1;
    assign ctrl_o = {28'd0, im_q, mode_q, en_q};
`endif

    assign preset_o = preset_q;
    assign count_o  = count_q;
    assign irq_o    = flag_q & im_q;

    // Next-state logic: FSM step, then bus writes which override EN/MODE/flag
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        flag_d   = flag_q;
        count_d  = count_q;
        preset_d = preset_we_i ? wdata_i : preset_q;
`ifdef TIMER_PRESCALE_EN
        ps_d     = ps_q;
        pscnt_d  = pscnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
                pscnt_d = 8'd0;
`endif
                state_d = (preset_q == 32'd0) ? ST_INT : ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (w_tick) begin
`ifdef TIMER_PRESCALE_EN
                    pscnt_d = 8'd0;
`endif
                    // COUNT never sits at 0 here, so no wrap can occur
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d = 32'd0;
                        state_d = ST_INT;
                    end
                end else begin
`ifdef TIMER_PRESCALE_EN
                    pscnt_d = pscnt_q + 8'd1;
`endif
                end
            end
            ST_INT: begin
                if (mode_q == MODE_AUTO) begin
                    state_d = ST_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flag rises on entry to INT; in auto-reload it lasts only that cycle
        if (state_d == ST_INT) begin
            flag_d = 1'b1;
        end else if (mode_q == MODE_AUTO) begin
            flag_d = 1'b0;
        end

        // A CTRL write wins over anything the FSM did this cycle
        if (ctrl_we_i) begin
            en_d   = wdata_i[CTRL_EN];
            mode_d = wdata_i[CTRL_MODE_HI:CTRL_MODE_LO];
            im_d   = wdata_i[CTRL_IM];
            flag_d = 1'b0;
`ifdef TIMER_PRESCALE_EN
            ps_d   = wdata_i[CTRL_PS_HI:CTRL_PS_LO];
`endif
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            im_q     <= 1'b0;
            flag_q   <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
`ifdef TIMER_PRESCALE_EN
            ps_q     <= 8'd0;
            pscnt_q  <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            flag_q   <= flag_d;
            preset_q <= preset_d;
            count_q  <= count_d;
`ifdef TIMER_PRESCALE_EN
            ps_q     <= ps_d;
            pscnt_q  <= pscnt_d;
`endif
        end
    end

endmodule : timer_channel
`default_nettype wire

// File: rtl/mmio_timer_array.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_timer_array
//  Purpose  : NCH-channel memory-mapped countdown timer. Decodes the bus
//             window into 16-byte channel slots, muxes read data and ORs
//             the per-channel interrupts. Optional per-channel prescaler
//             is enabled by macro TIMER_PRESCALE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_timer_array
    import timer_pkg::*;
#(
    parameter int NCH = 2,
    parameter int AW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] irq,
    output logic           irq_any
);

    localparam int CH_W = AW - 4;

    logic [NCH-1:0] w_sel;
    logic [3:0]     w_off;
    logic [31:0]    w_ctrl   [NCH];
    logic [31:0]    w_preset [NCH];
    logic [31:0]    w_count  [NCH];
    logic           w_unused_addr;

    // Word offset within the slot; byte lanes are not decoded
    assign w_off         = {addr[3:2], 2'b00};
    assign w_unused_addr = ^addr[1:0];

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            assign w_sel[c] = (addr[AW-1:4] == CH_W'(c));

            timer_channel u_chan (
                .clk         (clk),
                .rst         (rst),
                .ctrl_we_i   (we && w_sel[c] && (w_off == OFF_CTRL)),
                .preset_we_i (we && w_sel[c] && (w_off == OFF_PRESET)),
                .wdata_i     (wdata),
                .ctrl_o      (w_ctrl[c]),
                .preset_o    (w_preset[c]),
                .count_o     (w_count[c]),
                .irq_o       (irq[c])
            );
        end
    endgenerate

    assign irq_any = |irq;

    // Zero-latency read mux; unmapped slots and the reserved word read 0
    always_comb begin
        rdata = 32'd0;
        for (int c = 0; c < NCH; c++) begin
            if (w_sel[c]) begin
                case (w_off)
                    OFF_CTRL:   rdata = w_ctrl[c];
                    OFF_PRESET: rdata = w_preset[c];
                    OFF_COUNT:  rdata = w_count[c];
                    default:    rdata = 32'd0;
                endcase
            end
        end
    end

endmodule : mmio_timer_array
`default_nettype wire

// File: tb/tb_mmio_timer_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_timer_array
//  Purpose  : Self-checking bench for mmio_timer_array (NCH=2, AW=8):
//             register-access vector table plus timing sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_timer_array;

    localparam int NCH = 2;
    localparam int AW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           we = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [31:0]    wdata = '0;
    logic [31:0]    rdata;
    logic [NCH-1:0] irq;
    logic           irq_any;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wr_cyc = 0;

    mmio_timer_array #(.NCH(NCH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One write cycle; wr_cyc holds the cycle number of the write edge
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic goto_cyc(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    // Edges from t0 until irq[ch] is seen high at a falling edge; -1 on timeout
    task automatic measure_rise(input int ch, input int t0, input int bound, output int edges);
        edges = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (irq[ch]) begin
                edges = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          t0;
        int          edges;
        bit          found;
        bit          exp_p;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_irq", {30'd0, irq}, 32'd0);
        chk("reset_irq_any", {31'd0, irq_any}, 32'd0);

        // ---------------- register access table ----------------
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 8'(i * 4), 32'd0, 32'd0});
        tbl.push_back('{1'b0, 8'h20, 32'd0, 32'd0});
        tbl.push_back('{1'b0, 8'hFC, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 8'h08, 32'h0000_FFFF, 32'd0});
        tbl.push_back('{1'b1, 8'h04, 32'h1234_5678, 32'h1234_5678});
        tbl.push_back('{1'b1, 8'h04, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 8'h14, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        tbl.push_back('{1'b1, 8'h14, 32'd0, 32'd0});
`ifdef TIMER_PRESCALE_EN
        tbl.push_back('{1'b1, 8'h10, 32'hFFFF_FF06, 32'h0000_FF06});
`else
        tbl.push_back('{1'b1, 8'h10, 32'hFFFF_FF06, 32'h0000_0006});
`endif
        tbl.push_back('{1'b1, 8'h10, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 8'h0C, 32'h0000_1234, 32'd0});
        tbl.push_back('{1'b1, 8'h24, 32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b1, 8'h20, 32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b0, 8'h04, 32'd0, 32'd0});
        tbl.push_back('{1'b0, 8'h00, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 8'h00, 32'h0000_000E, 32'h0000_000E});
        tbl.push_back('{1'b1, 8'h00, 32'd0, 32'd0});

        foreach (tbl[i]) begin
            if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].wd);
            else @(negedge clk);
            bus_read(tbl[i].a, rd);
            chk($sformatf("tbl[%0d]@%02h", i, tbl[i].a), rd, tbl[i].exp);
        end
        chk("tbl_irq", {30'd0, irq}, 32'd0);

        // ---------------- ch0 one-shot, PRESET=5 ----------------
        bus_write(8'h04, 32'd5);
        bus_write(8'h00, 32'h9);
        t0 = wr_cyc;
        measure_rise(0, t0, 30, edges);
        chk("oneshot_rise_edges", edges, 32'd7);
        @(negedge clk);
        bus_read(8'h08, rd);
        chk("oneshot_count", rd, 32'd0);
        bus_read(8'h00, rd);
        chk("oneshot_ctrl", rd, 32'h8);
        repeat (5) @(negedge clk);
        chk("oneshot_sticky", {30'd0, irq}, 32'd1);
        chk("oneshot_irq_any", {31'd0, irq_any}, 32'd1);
        bus_write(8'h00, 32'h8);
        chk("oneshot_clear", {30'd0, irq}, 32'd0);

        // ---------------- ch1 auto-reload, PRESET=3 ----------------
        bus_write(8'h14, 32'd3);
        bus_write(8'h10, 32'hB);
        t0 = wr_cyc;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            exp_p = ((cyc - t0) > 0) && (((cyc - t0) % 5) == 0);
            chk($sformatf("auto_irq_k%0d", cyc - t0), {30'd0, irq}, {30'd0, exp_p, 1'b0});
            chk($sformatf("auto_any_k%0d", cyc - t0), {31'd0, irq_any}, {31'd0, exp_p});
        end
        bus_write(8'h10, 32'd0);
        repeat (12) @(negedge clk);
        chk("auto_stopped", {30'd0, irq}, 32'd0);

        // ---------------- ch0 stop mid-count, PRESET=100 ----------------
        bus_write(8'h04, 32'd100);
        bus_write(8'h00, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus_read(8'h08, rd);
            if (rd == 32'd60) begin
                found = 1'b1;
                break;
            end
        end
        chk("stop_reached_60", {31'd0, found}, 32'd1);
        we = 1'b1; addr = 8'h00; wdata = 32'd0;
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        bus_read(8'h08, rd);
        chk("stop_count_59", rd, 32'd59);
        repeat (6) @(negedge clk);
        bus_read(8'h08, rd);
        chk("stop_frozen", rd, 32'd59);
        chk("stop_no_irq", {30'd0, irq}, 32'd0);
        bus_write(8'h00, 32'h9);
        t0 = wr_cyc;
        goto_cyc(t0 + 2);
        bus_read(8'h08, rd);
        chk("restart_reload", rd, 32'd100);
        goto_cyc(t0 + 3);
        bus_read(8'h08, rd);
        chk("restart_dec", rd, 32'd99);
        bus_write(8'h00, 32'd0);

        // ---------------- PRESET=0, IM=0 ----------------
        bus_write(8'h04, 32'd0);
        bus_write(8'h00, 32'h1);
        t0 = wr_cyc;
        goto_cyc(t0 + 2);
        bus_read(8'h00, rd);
        chk("p0_ctrl_in_int", rd, 32'h1);
        goto_cyc(t0 + 3);
        bus_read(8'h00, rd);
        chk("p0_ctrl_after_int", rd, 32'h0);
        chk("p0_masked_irq", {30'd0, irq}, 32'd0);
        bus_write(8'h00, 32'h8);
        repeat (3) @(negedge clk);
        chk("p0_flag_cleared", {30'd0, irq}, 32'd0);

        // ---------------- PRESET write during CNT ----------------
        bus_write(8'h04, 32'd10);
        bus_write(8'h00, 32'h9);
        t0 = wr_cyc;
        goto_cyc(t0 + 3);
        bus_write(8'h04, 32'd2);
        measure_rise(0, t0, 40, edges);
        chk("preset_mid_cnt_rise", edges, 32'd12);
        @(negedge clk);
        bus_write(8'h00, 32'h9);
        t0 = wr_cyc;
        measure_rise(0, t0, 40, edges);
        chk("preset_next_load_rise", edges, 32'd4);
        bus_write(8'h00, 32'h8);
        chk("preset_clear", {30'd0, irq}, 32'd0);

        // ---------------- prescaler PS=3, PRESET=2 ----------------
        bus_write(8'h04, 32'd2);
        bus_write(8'h00, 32'h0000_0309);
        t0 = wr_cyc;
        measure_rise(0, t0, 40, edges);
`ifdef TIMER_PRESCALE_EN
        chk("prescale_rise", edges, 32'd10);
`else
        chk("prescale_rise", edges, 32'd4);
`endif
        @(negedge clk);
        bus_read(8'h00, rd);
`ifdef TIMER_PRESCALE_EN
        chk("prescale_ctrl", rd, 32'h308);
`else
        chk("prescale_ctrl", rd, 32'h8);
`endif
        bus_write(8'h00, 32'h8);

        // ---------------- reset during ch1 auto-reload ----------------
        bus_write(8'h14, 32'd3);
        bus_write(8'h10, 32'hB);
        t0 = wr_cyc;
        measure_rise(1, t0, 30, edges);
        chk("rst_pre_rise", edges, 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_irq", {30'd0, irq}, 32'd0);
        chk("rst_irq_any", {31'd0, irq_any}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_read(8'(i * 4), rd);
            chk($sformatf("rst_reg@%02h", i * 4), rd, 32'd0);
        end
        repeat (8) @(negedge clk);
        bus_read(8'h18, rd);
        chk("rst_ch1_idle", rd, 32'd0);
        chk("rst_irq_later", {30'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mmio_timer_array
`default_nettype wire
